alu_apb_master: RTL
===================

ALU_APB_MASTER -- requirements
Module: alu_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for ready (range 1..255).
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- sel  out  1  APB select to ALU slave
- en  out  1  APB enable
- write  out  1  APB direction
- addr  out  ADDR_W  APB address
- wdata  out  DATA_W  APB write data
- rdata  in  DATA_W  APB read data
- ready  in  1  APB slave ready
- slv_err  in  1  APB slave error, valid with ready
REQ-005 SHALL have the clock and reset exactly as decided: one clock clk; reset rst synchronous and active-high.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one state per cycle except ACCESS (waits) and RESP (holds).
REQ-007 SHALL assert cmd_ready only in IDLE (combinational from state).
REQ-008 IDLE: on cmd_valid, SHALL register cmd_write/addr/wdata into write/addr/wdata and go to SETUP next cycle.
REQ-009 SETUP: SHALL drive sel=1, en=0 for exactly one cycle, then go to ACCESS.
REQ-010 ACCESS: SHALL drive sel=1, en=1; remain until ready=1 sampled or timeout.
REQ-011 write, addr, wdata SHALL remain stable from SETUP through last ACCESS cycle.
REQ-012 On ready=1 in ACCESS: SHALL capture rdata (reads only; 0 for writes) into rsp_rdata, slv_err into rsp_err, rsp_timeout=0, go to RESP; sel and en low next cycle.
REQ-013 Timeout: 8-bit wait counter cleared on SETUP entry, incremented each ACCESS cycle with ready=0; when counter reaches TIMEOUT with ready=0, SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, dropping sel/en next cycle.
REQ-014 ready=1 in the same cycle the counter hits TIMEOUT SHALL be treated as normal completion (ready wins).
REQ-015 RESP: SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err/rsp_timeout until rsp_ready=1; then return to IDLE next cycle.
REQ-016 Latency: command accepted cycle N -> SETUP N+1 -> ACCESS N+2 -> with zero-wait slave, rsp_valid at N+3; minimum command-to-command spacing 4 cycles.
REQ-017 SHALL never assert en without sel; sel/en low in IDLE and RESP.
REQ-018 ready and slv_err SHALL be ignored outside ACCESS.
REQ-019 rsp_valid SHALL be registered; no combinational path from APB inputs to rsp_* outputs.

Reset
REQ-020 While rst=1 at a clock edge: state=IDLE, sel=0, en=0, write=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-021 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort immediately with no response produced; cmd_ready=1 on first cycle after rst deasserts.

Verification
REQ-022 Zero-wait write: cmd write addr=0x04 wdata=0x0000_00A5, ready=1 in ACCESS -> sel high 2 cycles, en high 1 cycle, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-023 Wait-state read: read addr=0x08, ready low 3 ACCESS cycles then high with rdata=0x1234_5678 -> addr stable throughout, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-024 Slave error: read with ready=1, slv_err=1 -> rsp_err=1, rsp_timeout=0.
REQ-025 Timeout: TIMEOUT=16, ready held 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0, sel/en low.
REQ-026 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> response held stable, cmd_ready=0, new cmd_valid not accepted until after handshake.
REQ-027 Reset mid-ACCESS: rst=1 one cycle during ACCESS -> sel=en=rsp_valid=0 next cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_apb_master.sv
// APB master bridging a valid/ready command port to a single APB slave.
// Four-state transfer FSM with a bounded ACCESS wait and a held response.
module alu_apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              sel,
   output logic              en,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              ready,
   input  logic              slv_err
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       time_up;

   // Last permitted ACCESS cycle with no ready; ready in that same cycle still completes.
   assign time_up = (wait_cnt == 8'(TIMEOUT - 1)) && !ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (ready || time_up) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // All handshake and APB strobes decode straight from the state register.
   always_comb begin
      cmd_ready = (state == IDLE);
      sel       = (state == SETUP) || (state == ACCESS);
      en        = (state == ACCESS);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write       <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         wait_cnt    <= 8'd0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               write    <= cmd_write;
               addr     <= cmd_addr;
               wdata    <= cmd_wdata;
               wait_cnt <= 8'd0;
            end
            ACCESS: begin
               if (ready) begin
                  rsp_rdata   <= write ? '0 : rdata;
                  rsp_err     <= slv_err;
                  rsp_timeout <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (time_up) begin
                     rsp_rdata   <= '0;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
